// File: rtl/divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package divider_pkg;

    localparam int unsigned DW_DEFAULT = 4;
    localparam int unsigned VW_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, conditionally subtract.
module div_step
    import divider_pkg::*;
#(
    parameter int unsigned VW = VW_DEFAULT
) (
    input  logic [VW:0]   rem_in,
    input  logic          dividend_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_out,
    output logic          q_bit
);

    localparam int unsigned RW = VW + 1;
    localparam int unsigned SW = VW + 2;

    // Compare at one extra bit so the shifted value can never wrap.
    always_comb begin
        q_bit   = ({rem_in, dividend_bit} >= SW'(divisor));
        rem_out = q_bit ? RW'({rem_in, dividend_bit} - SW'(divisor))
                        : RW'({rem_in, dividend_bit});
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: one restoring step per cycle, MSB first, registered results.
module seq_divider
    import divider_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned VW = VW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
    localparam int unsigned RW = VW + 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dsr_q, dsr_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic          busy_d, done_d, div_by_zero_d;
    logic [DW-1:0] quotient_d;
    logic [VW-1:0] remainder_d;

    logic [RW-1:0] step_rem;
    logic          step_q;
    logic [DW-1:0] quo_shift;

    div_step #(.VW(VW)) u_step (
        .rem_in       (rem_q),
        .dividend_bit (dvd_q[DW-1]),
        .divisor      (dsr_q),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // Next-state, working registers and result registers.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dvd_d         = dvd_q;
        dsr_d         = dsr_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        busy_d        = busy;
        done_d        = 1'b0;
        quotient_d    = quotient;
        remainder_d   = remainder;
        div_by_zero_d = div_by_zero;
        quo_shift     = DW'({quo_q, step_q});

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dsr_d = divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    quo_d = '0;
                    if (divisor == '0) begin
                        state_d       = FINISH;
                        done_d        = 1'b1;
                        quotient_d    = '1;
                        remainder_d   = '0;
                        div_by_zero_d = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = quo_shift;
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d       = FINISH;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    quotient_d    = quo_shift;
                    remainder_d   = step_rem[VW-1:0];
                    div_by_zero_d = 1'b0;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            busy        <= busy_d;
            done        <= done_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            div_by_zero <= div_by_zero_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor checks each done.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [1:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [1:0] remainder;
    logic       div_by_zero;

    typedef struct {
        int q;
        int r;
        int dbz;
        int cyc;
        int tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    seq_divider #(.DW(4), .VW(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drive a start pulse at the current negedge and wait until the DUT is back in IDLE.
    task automatic issue(input int a, input int b, input int q, input int r,
                         input int dbz, input int tag, input bit expect_done);
        exp_t e;
        dividend = 4'(a);
        divisor  = 2'(b);
        start    = 1'b1;
        e.q   = q;
        e.r   = r;
        e.dbz = dbz;
        e.cyc = (b == 0) ? cyc + 1 : cyc + 5;
        e.tag = tag;
        if (expect_done) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat ((b == 0) ? 1 : 5) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
                end else begin
                    e  = sb.pop_front();
                    ok = 1'b1;
                    ok &= chk("quotient", int'(quotient), e.q);
                    ok &= chk("remainder", int'(remainder), e.r);
                    ok &= chk("div_by_zero", int'(div_by_zero), e.dbz);
                    ok &= chk("done_cycle", cyc, e.cyc);
                    if (e.tag >= 0)
                        $display("sweep %0d*%0d/%0d : %s", e.tag / 4, e.tag % 4, e.tag % 4,
                                 ok ? "TRUE" : "FALSE");
                end
            end
        end
    end

    initial begin
        int c0;
        bit ok;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        ok = chk("rst_busy", int'(busy), 0);
        ok = chk("rst_done", int'(done), 0);
        ok = chk("rst_quotient", int'(quotient), 0);
        ok = chk("rst_remainder", int'(remainder), 0);
        ok = chk("rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(9, 3, 3, 0, 0, -1, 1'b1);
        issue(15, 2, 7, 1, 0, -1, 1'b1);
        issue(0, 1, 0, 0, 0, -1, 1'b1);
        issue(6, 0, 15, 0, 1, -1, 1'b1);
        issue(7, 3, 2, 1, 0, -1, 1'b1);

        for (int a = 0; a < 4; a++)
            for (int b = 1; b < 4; b++)
                issue(a * b, b, a, 0, 0, a * 4 + b, 1'b1);

        // Start while busy must be ignored, operand changes mid-CALC too.
        dividend = 4'd9;
        divisor  = 2'd3;
        start    = 1'b1;
        begin
            exp_t e;
            e.q = 3; e.r = 0; e.dbz = 0; e.cyc = cyc + 5; e.tag = -1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 2'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = chk("busy_in_calc", int'(busy), 1);
        repeat (3) @(negedge clk);
        ok = chk("busy_after_done", int'(busy), 0);
        c0 = cyc;
        dividend = 4'd14;
        divisor  = 2'd3;
        start    = 1'b1;
        begin
            exp_t e;
            e.q = 4; e.r = 2; e.dbz = 0; e.cyc = c0 + 5; e.tag = -1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        ok = chk("quotient_held", int'(quotient), 3);
        ok = chk("remainder_held", int'(remainder), 0);
        repeat (4) @(negedge clk);

        // Reset mid-CALC aborts; no done may follow.
        dividend = 4'd9;
        divisor  = 2'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        ok = chk("abort_busy", int'(busy), 0);
        ok = chk("abort_done", int'(done), 0);
        ok = chk("abort_quotient", int'(quotient), 0);
        ok = chk("abort_remainder", int'(remainder), 0);
        ok = chk("abort_dbz", int'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(8, 2, 4, 0, 0, -1, 1'b1);

        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        ok = chk("pending_results", sb.size(), 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
